lap_stopwatch: RTL and testbench
================================

// Module: lap_stopwatch
// PURPOSE
//  Parametrised BCD stopwatch with tenths resolution, configurable minute-digit count and an internal prescaler.
//  Replaces the fixed 4-digit start/stop chain. Adds pause/resume, lap (split) capture with a frozen display,
//  and overflow handling. Sits between the debounced button pulses and the 7-segment display mux.
// PARAMETERS
//  TICK_DIV    10  clk cycles per 0.1 s tick (>=2); sim uses 10, board uses clk_hz/10
//  MIN_DIGITS  2   number of BCD minute digits (1..4); max count = (10^MIN_DIGITS-1):59.9
//  WRAP        0   0: saturate at max with sticky overflow; 1: roll to all-zero with 1-cycle overflow pulse
//  HIST_DEPTH  4   lap history entries (power of 2, >=2); used only with LAP_STOPWATCH_HISTORY_EN
// PORTS
//  clk          in   1              system clock, rising edge
//  reset        in   1              asynchronous, active-low reset
//  clear        in   1              sync clear pulse, 1 cycle
//  start_stop   in   1              toggle pulse, 1 cycle
//  lap          in   1              lap/split pulse, 1 cycle
//  digits       out  4*(MIN_DIGITS+3)  displayed BCD, {min[MSD..0], sec1, sec0, tenth}
//  running      out  1              1 in RUN
//  lap_active   out  1              display shows frozen lap value
//  overflow     out  1              see WRAP
//  tenth_tick   out  1              1-cycle strobe on each live tenth increment
// BEHAVIOUR
//  - Reset (reset=0): state IDLE; live count, lap reg and prescaler = 0; all outputs 0.
//  - FSM IDLE/RUN/PAUSE. start_stop: IDLE->RUN, RUN->PAUSE, PAUSE->RUN. clear: any state->IDLE, zeroing count,
//    prescaler, lap reg, lap_active, overflow. clear beats start_stop and lap in the same cycle.
//  - Prescaler counts 0..TICK_DIV-1 only in RUN. It holds in PAUSE (resume keeps the partial tick) and is zeroed in IDLE.
//    The tick fires on the cycle prescaler==TICK_DIV-1 in RUN. The tenth digit updates on that edge; tenth_tick is high that cycle.
//  - Digit chain: tenth mod10 -> sec0 mod10 -> sec1 mod6 -> min[0..MIN_DIGITS-1] mod10.
//    Carries are combinational and ripple within one tick. Every digit is always a legal BCD value.
//  - Max value with a tick: WRAP=0 holds max, sets overflow=1 (sticky until clear/reset), and no further tenth_tick.
//    WRAP=1 goes to all-zero, overflow=1 for that cycle only.
//  - start_stop while saturated (WRAP=0) still toggles RUN/PAUSE; the count stays at max.
//  - lap in RUN: lap reg <= live value *before* any same-edge increment; lap_active=1. A repeat lap re-captures (split).
//  - lap in PAUSE: if lap_active then lap_active=0 (display returns live), else capture as in RUN. lap in IDLE is ignored.
//  - start_stop and lap in the same cycle: the capture uses the pre-edge value, then the state transition applies.
//  - digits = lap_active ? lap reg : live count. Outputs are registered or mux of registers; no combinational path from inputs.
//  - Async reset assert mid-count clears immediately. Deassert is sync'd externally; the block does not resynchronise.
// CONFIGURATION
//  - `LAP_STOPWATCH_HISTORY_EN defined: every lap capture is also pushed into a HIST_DEPTH circular buffer.
//    The oldest entry is overwritten when full. Extra ports:
//      hist_idx   in  $clog2(HIST_DEPTH)  0 = newest
//      hist_data  out 4*(MIN_DIGITS+3)    registered, 1-cycle read latency
//      hist_count out $clog2(HIST_DEPTH)+1  valid entries, saturating at HIST_DEPTH
//    clear/reset empty the buffer (count=0, data reads 0). An idx >= hist_count reads 0.
//  - Undefined: no buffer, no extra ports; all other behaviour is identical.
// STRUCTURE
//  - stopwatch_pkg: sw_state_e {SW_IDLE, SW_RUN, SW_PAUSE}; bcd_t (4-bit);
//    constants SEC1_MOD=6, DIGIT_MOD=10; function digits_width(MIN_DIGITS).
//  - Sub-module bcd_digit_counter #(MOD): clk, reset, clr, en, sat_hold -> q[3:0], at_max, carry_out.
//    Instantiated once per digit via generate; the top holds the FSM, prescaler, lap reg and optional history.
// TESTING (TICK_DIV=10, MIN_DIGITS=2, WRAP=0 unless stated)
//  1. reset, start_stop, wait 100 clk -> digits=00:00.9 and tenth_tick seen 9x. 10 more clk -> 00:01.0.
//  2. Run to 00:59.9, one tick -> 01:00.0. Preset 99:59.9 + one tick -> holds 99:59.9, overflow=1 sticky.
//     WRAP=1 -> 00:00.0, overflow pulses 1 cycle.
//  3. Run 35 clk, start_stop (pause), wait 50, start_stop, wait 5 -> 00:00.4; the partial tick is preserved.
//  4. At 00:02.3 pulse lap -> digits frozen 00:02.3 while live advances. Pause, lap -> display live. lap in IDLE -> no change.
//  5. clear + start_stop + lap same cycle during RUN -> IDLE, all zero, running=0, lap_active=0, overflow=0.
//  6. HISTORY_EN: 5 laps at 1,2,3,4,5 s -> hist_count=4; idx0=00:05.0, idx3=00:02.0. Async reset mid-run -> zeros at once.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the lap stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'd0,
        SW_RUN   = 2'd1,
        SW_PAUSE = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam int SEC1_MOD  = 6;
    localparam int DIGIT_MOD = 10;

    function automatic int digits_width(input int min_digits);
        return 4 * (min_digits + 3);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one modulo-MOD BCD digit with ripple carry and saturation hold
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MOD = DIGIT_MOD
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic sat_hold,
    output bcd_t q,
    output logic at_max,
    output logic carry_out
);

    assign at_max    = (q == bcd_t'(MOD - 1));
    assign carry_out = en && at_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !sat_hold) begin
            q <= at_max ? '0 : q + bcd_t'(1);
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// rtl/lap_stopwatch.sv - BCD tenths stopwatch with pause, lap freeze and overflow
// Optional lap history buffer: LAP_STOPWATCH_HISTORY_EN
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 10,
    parameter int MIN_DIGITS = 2,
    parameter int WRAP       = 0,
    parameter int HIST_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clear,
    input  logic                                start_stop,
    input  logic                                lap,
    output logic [digits_width(MIN_DIGITS)-1:0] digits,
    output logic                                running,
    output logic                                lap_active,
    output logic                                overflow,
    output logic                                tenth_tick
`ifdef LAP_STOPWATCH_HISTORY_EN
    ,
    input  logic [$clog2(HIST_DEPTH)-1:0]       hist_idx,
    output logic [digits_width(MIN_DIGITS)-1:0] hist_data,
    output logic [$clog2(HIST_DEPTH):0]         hist_count
`endif
);

    localparam int NDIG = MIN_DIGITS + 3;
    localparam int DW   = digits_width(MIN_DIGITS);
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || HIST_DEPTH < 2) begin : g_bad_params
        $error("lap_stopwatch: TICK_DIV and HIST_DEPTH must be >= 2");
    end

    sw_state_e       state_q, state_d;
    logic [PW-1:0]   presc_q;
    logic            tick;
    logic            all_max;
    logic            sat_hold;
    logic            wrap_evt;
    bcd_t            q [NDIG];
    logic [NDIG-1:0] at_max_v;
    logic [NDIG:0]   en_v;
    logic [DW-1:0]   live;
    logic [DW-1:0]   lap_q;
    logic            lap_active_q, lap_active_d;
    logic            capture;
    logic            overflow_q;

    assign tick     = (state_q == SW_RUN) && (presc_q == PRESC_MAX);
    assign all_max  = &at_max_v;
    assign sat_hold = (WRAP == 0) && all_max;
    assign en_v[0]  = tick;
    // The carry out of the top digit only fires when every digit was at max.
    assign wrap_evt = en_v[NDIG];

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        bcd_digit_counter #(
            .MOD((i == 2) ? SEC1_MOD : DIGIT_MOD)
        ) u_digit (
            .clk      (clk),
            .reset    (reset),
            .clr      (clear),
            .en       (en_v[i]),
            .sat_hold (sat_hold),
            .q        (q[i]),
            .at_max   (at_max_v[i]),
            .carry_out(en_v[i+1])
        );
        assign live[4*i +: 4] = q[i];
    end

    always_comb begin
        state_d      = state_q;
        lap_active_d = lap_active_q;
        capture      = 1'b0;
        if (clear) begin
            state_d      = SW_IDLE;
            lap_active_d = 1'b0;
        end else begin
            // Capture sees the pre-edge state, so lap+start_stop acts on the old mode.
            case (state_q)
                SW_RUN: begin
                    if (lap) begin
                        capture      = 1'b1;
                        lap_active_d = 1'b1;
                    end
                end
                SW_PAUSE: begin
                    if (lap) begin
                        if (lap_active_q) begin
                            lap_active_d = 1'b0;
                        end else begin
                            capture      = 1'b1;
                            lap_active_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (start_stop) begin
                case (state_q)
                    SW_IDLE:  state_d = SW_RUN;
                    SW_RUN:   state_d = SW_PAUSE;
                    default:  state_d = SW_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SW_IDLE;
            presc_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lap_active_q <= lap_active_d;
            if (clear) begin
                presc_q    <= '0;
                lap_q      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (state_q == SW_RUN) begin
                    presc_q <= tick ? '0 : presc_q + PW'(1);
                end
                if (capture) begin
                    lap_q <= live;
                end
                if (WRAP != 0) begin
                    overflow_q <= wrap_evt;
                end else if (wrap_evt) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    assign digits     = lap_active_q ? lap_q : live;
    assign running    = (state_q == SW_RUN);
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;
    assign tenth_tick = tick && !sat_hold;

`ifdef LAP_STOPWATCH_HISTORY_EN
    localparam int HW = $clog2(HIST_DEPTH);

    logic [DW-1:0] hist_mem [HIST_DEPTH];
    logic [HW-1:0] wr_ptr;
    logic [HW-1:0] rd_ptr;
    logic [HW:0]   count;

    // Newest entry sits just behind the write pointer.
    assign rd_ptr     = wr_ptr - HW'(1) - hist_idx;
    assign hist_count = count;

    always_ff @(posedge clk) begin
        if (capture) begin
            hist_mem[wr_ptr] <= live;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            hist_data <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            count     <= '0;
            hist_data <= '0;
        end else begin
            hist_data <= ({1'b0, hist_idx} < count) ? hist_mem[rd_ptr] : '0;
            if (capture) begin
                wr_ptr <= wr_ptr + HW'(1);
                if (count != (HW+1)'(HIST_DEPTH)) begin
                    count <= count + (HW+1)'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb/tb_lap_stopwatch.sv - randomized check of three stopwatch configurations against a tenths-count model
module tb_lap_stopwatch;

    logic clk = 1'b0;
    logic reset;
    logic clear, start_stop, lap;
    logic [1:0] hist_idx;

    logic [19:0] dig0;
    logic [15:0] dig1, dig2;
    logic [2:0] run_v, la_v, ov_v, tt_v;
`ifdef LAP_STOPWATCH_HISTORY_EN
    logic [19:0] hd0;
    logic [15:0] hd1, hd2;
    logic [2:0]  hc0, hc1, hc2;
`endif

    always #5 clk = ~clk;

    lap_stopwatch #(.TICK_DIV(10), .MIN_DIGITS(2), .WRAP(0), .HIST_DEPTH(4)) u_d0 (
        .clk(clk), .reset(reset), .clear(clear), .start_stop(start_stop), .lap(lap),
        .digits(dig0), .running(run_v[0]), .lap_active(la_v[0]), .overflow(ov_v[0]), .tenth_tick(tt_v[0])
`ifdef LAP_STOPWATCH_HISTORY_EN
        , .hist_idx(hist_idx), .hist_data(hd0), .hist_count(hc0)
`endif
    );

    lap_stopwatch #(.TICK_DIV(2), .MIN_DIGITS(1), .WRAP(0), .HIST_DEPTH(4)) u_d1 (
        .clk(clk), .reset(reset), .clear(clear), .start_stop(start_stop), .lap(lap),
        .digits(dig1), .running(run_v[1]), .lap_active(la_v[1]), .overflow(ov_v[1]), .tenth_tick(tt_v[1])
`ifdef LAP_STOPWATCH_HISTORY_EN
        , .hist_idx(hist_idx), .hist_data(hd1), .hist_count(hc1)
`endif
    );

    lap_stopwatch #(.TICK_DIV(2), .MIN_DIGITS(1), .WRAP(1), .HIST_DEPTH(4)) u_d2 (
        .clk(clk), .reset(reset), .clear(clear), .start_stop(start_stop), .lap(lap),
        .digits(dig2), .running(run_v[2]), .lap_active(la_v[2]), .overflow(ov_v[2]), .tenth_tick(tt_v[2])
`ifdef LAP_STOPWATCH_HISTORY_EN
        , .hist_idx(hist_idx), .hist_data(hd2), .hist_count(hc2)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: live time as a plain count of tenths; state 0 idle, 1 run, 2 pause.
    int td [3] = '{10, 2, 2};
    int md [3] = '{2, 1, 1};
    int wr [3] = '{0, 0, 1};
    int st [3];
    int presc [3];
    int cnt [3];
    int lapv [3];
    bit la [3];
    bit ov [3];
    int hq [$];
    logic [31:0] exp_hd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int t, input int nmin);
        logic [31:0] r;
        int s, m;
        s = t / 10;
        m = s / 60;
        r = 32'(t % 10) | (32'((s % 60) % 10) << 4) | (32'((s % 60) / 10) << 8);
        for (int i = 0; i < nmin; i++) begin
            r = r | (32'(m % 10) << (12 + 4 * i));
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int max_cnt(input int k);
        return (10 ** md[k]) * 600 - 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            st[k] = 0; presc[k] = 0; cnt[k] = 0; lapv[k] = 0; la[k] = 0; ov[k] = 0;
        end
        hq.delete();
        exp_hd = '0;
    endtask

    task automatic model_step(input bit c, input bit ss, input bit lp, input int idx);
        bit tk, cap, sat;
        for (int k = 0; k < 3; k++) begin
            tk  = (st[k] == 1) && (presc[k] == td[k] - 1);
            sat = (cnt[k] == max_cnt(k));
            if (c) begin
                st[k] = 0; presc[k] = 0; cnt[k] = 0; lapv[k] = 0; la[k] = 0; ov[k] = 0;
                if (k == 0) begin
                    hq.delete();
                    exp_hd = '0;
                end
            end else begin
                cap = 0;
                if (lp && st[k] == 1) begin
                    cap = 1; la[k] = 1;
                end else if (lp && st[k] == 2) begin
                    if (la[k]) la[k] = 0;
                    else begin cap = 1; la[k] = 1; end
                end
                if (k == 0) begin
                    exp_hd = (idx < hq.size()) ? to_bcd(hq[idx], md[0]) : 32'd0;
                    if (cap) begin
                        hq.push_front(cnt[0]);
                        if (hq.size() > 4) void'(hq.pop_back());
                    end
                end
                if (cap) lapv[k] = cnt[k];
                if (wr[k] != 0) ov[k] = tk && sat;
                else ov[k] = ov[k] || (tk && sat);
                if (tk) cnt[k] = sat ? ((wr[k] != 0) ? 0 : cnt[k]) : cnt[k] + 1;
                if (st[k] == 1) presc[k] = (presc[k] == td[k] - 1) ? 0 : presc[k] + 1;
                if (ss) st[k] = (st[k] == 1) ? 2 : 1;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] d;
        bit tk;
        for (int k = 0; k < 3; k++) begin
            d  = (k == 0) ? 32'(dig0) : (k == 1) ? 32'(dig1) : 32'(dig2);
            tk = (st[k] == 1) && (presc[k] == td[k] - 1) && !(wr[k] == 0 && cnt[k] == max_cnt(k));
            check_eq($sformatf("d%0d.digits", k), d, la[k] ? to_bcd(lapv[k], md[k]) : to_bcd(cnt[k], md[k]));
            check_eq($sformatf("d%0d.running", k), 32'(run_v[k]), 32'(st[k] == 1));
            check_eq($sformatf("d%0d.lap_active", k), 32'(la_v[k]), 32'(la[k]));
            check_eq($sformatf("d%0d.overflow", k), 32'(ov_v[k]), 32'(ov[k]));
            check_eq($sformatf("d%0d.tenth_tick", k), 32'(tt_v[k]), 32'(tk));
        end
`ifdef LAP_STOPWATCH_HISTORY_EN
        check_eq("d0.hist_data", 32'(hd0), exp_hd);
        check_eq("d0.hist_count", 32'(hc0), 32'(hq.size()));
`endif
    endtask

    task automatic drive(input bit c, input bit ss, input bit lp);
        int idx;
        idx        = int'($urandom_range(0, 3));
        clear      = c;
        start_stop = ss;
        lap        = lp;
        hist_idx   = 2'(idx);
        model_step(c, ss, lp, idx);
    endtask

    // Per-mille probabilities for each pulse input.
    task automatic run_cycles(input int n, input int p_clr, input int p_ss, input int p_lap);
        repeat (n) begin
            @(negedge clk);
            check_all();
            drive($urandom_range(0, 999) < p_clr, $urandom_range(0, 999) < p_ss,
                  $urandom_range(0, 999) < p_lap);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0; start_stop = 1'b0; lap = 1'b0; hist_idx = 2'd0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        reset = 1'b1;

        run_cycles(3000, 3, 30, 30);

        // clear together with start_stop and lap, then a long uninterrupted run to max
        @(negedge clk); check_all(); drive(1'b0, 1'b1, 1'b0);
        run_cycles(200, 0, 0, 0);
        @(negedge clk); check_all(); drive(1'b1, 1'b1, 1'b1);
        @(negedge clk); check_all(); drive(1'b0, 1'b1, 1'b0);
        run_cycles(12200, 0, 0, 3);
        run_cycles(1000, 0, 20, 20);
        run_cycles(2000, 2, 30, 30);

        // asynchronous reset between clock edges must clear at once
        @(negedge clk);
        check_all();
        clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
        model_step(1'b0, 1'b0, 1'b0, int'(hist_idx));
        @(posedge clk);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        run_cycles(300, 2, 30, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
